// File: rtl/controle_navegacao_if.sv
// Bus between the navigation sequencer and its surroundings:
// sensor/command inputs plus actuator and position outputs.
interface controle_navegacao_if #(
  parameter int W = 4
);
  logic         iniciar;
  logic         parar;
  logic         sensor_frente;
  logic         sensor_esquerda;
  logic         lixo;
  logic [2:0]   orientacao;
  logic         girar;
  logic         avancar;
  logic         remover;
  logic         ocupado;
  logic         preso;
  logic [W-1:0] pos_x;
  logic [W-1:0] pos_y;

  modport slave (
    input  iniciar, parar, sensor_frente, sensor_esquerda, lixo, orientacao,
    output girar, avancar, remover, ocupado, preso, pos_x, pos_y
  );

  modport master (
    output iniciar, parar, sensor_frente, sensor_esquerda, lixo, orientacao,
    input  girar, avancar, remover, ocupado, preso, pos_x, pos_y
  );
endinterface

// File: rtl/controle_navegacao.sv
// Left-hand wall-following sequencer: decides turns/steps from the sensors,
// pulses the orientation unit, drives the motor/brush and tracks grid position.
module controle_navegacao #(
  parameter int W             = 4,
  parameter int PASSO_CICLOS  = 8,
  parameter int LIMPA_CICLOS  = 4,
  parameter int ESPERA_SENSOR = 2,
  parameter int MAX_GIROS     = 4
) (
  input logic                   clockc3,
  input logic                   reset,
  controle_navegacao_if.slave   bus
);

  localparam logic [2:0] PARADO   = 3'd0;
  localparam logic [2:0] DECIDE   = 3'd1;
  localparam logic [2:0] GIRA_ESQ = 3'd2;
  localparam logic [2:0] GIRA_DIR = 3'd3;
  localparam logic [2:0] ESPERA   = 3'd4;
  localparam logic [2:0] AVANCA   = 3'd5;
  localparam logic [2:0] LIMPA    = 3'd6;
  localparam logic [2:0] PRESO    = 3'd7;

  localparam int CMAX_A = (PASSO_CICLOS > LIMPA_CICLOS) ? PASSO_CICLOS : LIMPA_CICLOS;
  localparam int CMAX_B = (CMAX_A > ESPERA_SENSOR) ? CMAX_A : ESPERA_SENSOR;
  localparam int CMAX   = (CMAX_B > 5) ? CMAX_B : 5;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int GW     = $clog2(MAX_GIROS + 1);

  localparam logic [CW-1:0] PASSO_FIM  = CW'(PASSO_CICLOS - 1);
  localparam logic [CW-1:0] LIMPA_FIM  = CW'(LIMPA_CICLOS - 1);
  localparam logic [CW-1:0] ESPERA_FIM = CW'(ESPERA_SENSOR - 1);
  localparam logic [CW-1:0] GIRA_FIM   = CW'(4);
  localparam logic [GW-1:0] GIRO_MAX   = GW'(MAX_GIROS);

  localparam logic [2:0] NORTE = 3'b001;
  localparam logic [2:0] OESTE = 3'b010;
  localparam logic [2:0] LESTE = 3'b011;
  localparam logic [2:0] SUL   = 3'b100;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == {W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [W-1:0] sat_dec(input logic [W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] giro_q, giro_d, giro_inc;
  logic          pos_esq_q, pos_esq_d;
  logic [W-1:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic          girar_q, girar_d;
  logic          avancar_q, avancar_d;
  logic          remover_q, remover_d;
  logic          ocupado_q, ocupado_d;
  logic          preso_q, preso_d;

  assign giro_inc = giro_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    giro_d    = giro_q;
    pos_esq_d = pos_esq_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    if (bus.parar) begin
      state_d = PARADO;
      cnt_d   = '0;
    end else begin
      case (state_q)
        PARADO: if (bus.iniciar) begin
          state_d = DECIDE;
          giro_d  = '0;
          cnt_d   = '0;
        end
        DECIDE: begin
          cnt_d = '0;
          if (!bus.sensor_esquerda)    state_d = GIRA_ESQ;
          else if (!bus.sensor_frente) state_d = AVANCA;
          else                         state_d = GIRA_DIR;
        end
        GIRA_ESQ: begin
          state_d   = ESPERA;
          pos_esq_d = 1'b1;
          cnt_d     = '0;
        end
        // Three left pulses spaced by idle cycles make one right turn.
        GIRA_DIR: begin
          if (cnt_q == GIRA_FIM) begin
            cnt_d  = '0;
            giro_d = giro_inc;
            if (giro_inc == GIRO_MAX) begin
              state_d = PRESO;
            end else begin
              state_d   = ESPERA;
              pos_esq_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // After a left turn only the front is checked, so it never spins left.
        ESPERA: begin
          if (cnt_q == ESPERA_FIM) begin
            cnt_d = '0;
            if (pos_esq_q) state_d = bus.sensor_frente ? GIRA_DIR : AVANCA;
            else           state_d = DECIDE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        AVANCA: begin
          if (cnt_q == PASSO_FIM) begin
            cnt_d  = '0;
            giro_d = '0;
            case (bus.orientacao)
              NORTE:   pos_y_d = sat_inc(pos_y_q);
              SUL:     pos_y_d = sat_dec(pos_y_q);
              LESTE:   pos_x_d = sat_inc(pos_x_q);
              OESTE:   pos_x_d = sat_dec(pos_x_q);
              default: ;
            endcase
            state_d = bus.lixo ? LIMPA : DECIDE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LIMPA: begin
          if (cnt_q == LIMPA_FIM) begin
            cnt_d   = '0;
            state_d = DECIDE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESO:   state_d = PRESO;
        default: state_d = PARADO;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    girar_d   = (state_d == GIRA_ESQ) || ((state_d == GIRA_DIR) && !cnt_d[0]);
    avancar_d = (state_d == AVANCA);
    remover_d = (state_d == LIMPA);
    ocupado_d = (state_d != PARADO);
    preso_d   = (state_d == PRESO);
  end

  always_ff @(posedge clockc3 or negedge reset) begin
    if (!reset) begin
      state_q   <= PARADO;
      cnt_q     <= '0;
      giro_q    <= '0;
      pos_esq_q <= 1'b0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      girar_q   <= 1'b0;
      avancar_q <= 1'b0;
      remover_q <= 1'b0;
      ocupado_q <= 1'b0;
      preso_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      giro_q    <= giro_d;
      pos_esq_q <= pos_esq_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      girar_q   <= girar_d;
      avancar_q <= avancar_d;
      remover_q <= remover_d;
      ocupado_q <= ocupado_d;
      preso_q   <= preso_d;
    end
  end

  assign bus.girar   = girar_q;
  assign bus.avancar = avancar_q;
  assign bus.remover = remover_q;
  assign bus.ocupado = ocupado_q;
  assign bus.preso   = preso_q;
  assign bus.pos_x   = pos_x_q;
  assign bus.pos_y   = pos_y_q;

endmodule

// File: tb/tb_controle_navegacao.sv
// Directed bench for controle_navegacao: steps, turns, stuck detection,
// saturation, cleaning, stop and asynchronous reset.
module tb_controle_navegacao;
  logic clockc3 = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] gv, pv;
  int   c, gsum;

  controle_navegacao_if #(.W(4)) bus ();

  controle_navegacao #(
    .W(4), .PASSO_CICLOS(8), .LIMPA_CICLOS(4), .ESPERA_SENSOR(2), .MAX_GIROS(4)
  ) dut (
    .clockc3 (clockc3),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clockc3 = ~clockc3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clockc3);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset               = 1'b0;
    bus.iniciar         = 1'b0;
    bus.parar           = 1'b0;
    bus.sensor_frente   = 1'b0;
    bus.sensor_esquerda = 1'b0;
    bus.lixo            = 1'b0;
    bus.orientacao      = 3'b001;
    tickn(2);
    chk("reset_outs", {27'd0, bus.girar, bus.avancar, bus.remover, bus.ocupado, bus.preso}, 32'd0);
    chk("reset_pos", {24'd0, bus.pos_x, bus.pos_y}, 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_ocupado", bus.ocupado, 0);

    // Single step north
    bus.sensor_esquerda = 1'b1;
    bus.sensor_frente   = 1'b0;
    bus.iniciar         = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    chk("start_ocupado", bus.ocupado, 1);
    tick();
    c = 0; gsum = 0;
    while (bus.avancar === 1'b1 && c < 20) begin
      c++;
      gsum += bus.girar;
      tick();
    end
    chk("step_len", c, 8);
    chk("step_pos_y", bus.pos_y, 1);
    chk("step_pos_x", bus.pos_x, 0);
    chk("step_no_girar", gsum, 0);
    bus.parar = 1'b1;
    tick();
    bus.parar = 1'b0;
    chk("stop_ocupado", bus.ocupado, 0);
    chk("stop_keeps_pos", bus.pos_y, 1);

    // Boxed in: four right turns then stuck
    bus.sensor_frente = 1'b1;
    bus.iniciar       = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      gv[i] = bus.girar;
      pv[i] = bus.preso;
    end
    chk("dir_girar_pattern", gv, 32'h15151515);
    chk("dir_preso_pattern", pv, 32'hE0000000);
    bus.iniciar = 1'b1;
    tickn(3);
    bus.iniciar = 1'b0;
    chk("preso_hold", bus.preso, 1);
    chk("preso_actuators", {29'd0, bus.girar, bus.avancar, bus.remover}, 0);
    bus.parar = 1'b1;
    tick();
    bus.parar = 1'b0;
    chk("preso_exit", {30'd0, bus.preso, bus.ocupado}, 0);

    // Left free, then blocked after the turn
    bus.sensor_esquerda = 1'b0;
    bus.sensor_frente   = 1'b0;
    bus.iniciar         = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    tick();
    gv    = '0;
    gv[0] = bus.girar;
    bus.sensor_esquerda = 1'b1;
    bus.sensor_frente   = 1'b1;
    for (int i = 1; i < 11; i++) begin
      tick();
      gv[i] = bus.girar;
    end
    chk("esq_then_dir", gv, 32'h000000A9);
    bus.parar = 1'b1;
    tick();
    bus.parar = 1'b0;

    // Saturation and heading decode
    bus.sensor_frente = 1'b0;
    bus.orientacao    = 3'b010;
    bus.iniciar       = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    tickn(9);
    chk("oeste_sat_x", bus.pos_x, 0);
    chk("oeste_keep_y", bus.pos_y, 1);
    bus.orientacao = 3'b011;
    tickn(135);
    chk("leste_15", bus.pos_x, 15);
    tickn(9);
    chk("leste_sat_x", bus.pos_x, 15);
    bus.orientacao = 3'b000;
    tickn(9);
    chk("bad_heading", {24'd0, bus.pos_x, bus.pos_y}, 32'h000000F1);
    bus.orientacao = 3'b100;
    tickn(9);
    chk("sul_y", bus.pos_y, 0);
    tickn(9);
    chk("sul_sat_y", bus.pos_y, 0);

    // Trash at step end
    bus.orientacao = 3'b001;
    bus.lixo       = 1'b1;
    tickn(9);
    bus.lixo = 1'b0;
    chk("lixo_pos_y", bus.pos_y, 1);
    chk("lixo_no_avancar", bus.avancar, 0);
    c = 0;
    while (bus.remover === 1'b1 && c < 20) begin
      c++;
      tick();
    end
    chk("remover_len", c, 4);

    // Stop in the middle of a step
    tick();
    chk("abort_step_on", bus.avancar, 1);
    tick();
    bus.parar = 1'b1;
    tick();
    bus.parar = 1'b0;
    chk("abort_avancar", bus.avancar, 0);
    chk("abort_ocupado", bus.ocupado, 0);
    chk("abort_pos", {24'd0, bus.pos_x, bus.pos_y}, 32'h000000F1);

    // Asynchronous reset mid-step
    bus.iniciar = 1'b1;
    tickn(3);
    bus.iniciar = 1'b0;
    chk("prereset_avancar", bus.avancar, 1);
    reset = 1'b0;
    #1;
    chk("areset_outs", {27'd0, bus.girar, bus.avancar, bus.remover, bus.ocupado, bus.preso}, 0);
    chk("areset_pos", {24'd0, bus.pos_x, bus.pos_y}, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_reset_idle", {30'd0, bus.ocupado, bus.avancar}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
